// File: rtl/simd_wb_pkg.sv
// Shared types and constants for the SIMD result writeback buffer.
// Result layout: [67:66] ptype, [65] guard, [64:33] lane1, [32] guard, [31:0] lane0.
package simd_wb_pkg;

  localparam logic [1:0] ptype_int = 2'b00;
  localparam int PTYPE_LSB = 66;
  localparam int GUARD_HI  = 65;
  localparam int GUARD_LO  = 32;
  localparam int SIMD_RESW = 68;
  // The entry tag is fixed here, so the top-level TAGW must match it.
  localparam int SIMD_TAGW = 9;

  typedef struct packed {
    logic [SIMD_TAGW-1:0] tag;
    logic [SIMD_RESW-1:0] data;
  } simd_wb_entry_t;

  function automatic logic [15:0] pcount(input logic [31:0] v);
    pcount = '0;
    for (int i = 0; i < 32; i++) pcount = pcount + 16'(v[i]);
  endfunction

  function automatic logic fmt_bad(input logic [SIMD_RESW-1:0] d);
    fmt_bad = d[GUARD_HI] | d[GUARD_LO] | (d[PTYPE_LSB+1:PTYPE_LSB] != ptype_int);
  endfunction

endpackage

// File: rtl/simd_result_wb_tag_pipe.sv
// simd_tag_pipe: LAT-deep {valid, tag} shift register aligned with the SIMD unit.
// Also exports the next-state valid vector so the parent can register stall.
module simd_tag_pipe #(
  parameter int LAT  = 2,
  parameter int TAGW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic [TAGW-1:0] tag,
  output logic            last_vld,
  output logic [TAGW-1:0] last_tag,
  output logic [LAT-1:0]  vld_nxt
);

  logic [LAT-1:0]  vld;
  logic [TAGW-1:0] tags [LAT];

  always_comb begin
    vld_nxt = '0;
    if (!flush) begin
      vld_nxt[0] = en;
      for (int k = 1; k < LAT; k++) vld_nxt[k] = vld[k-1];
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) tags[k] <= '0;
    end else begin
      vld     <= vld_nxt;
      tags[0] <= tag;
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  end

  assign last_vld = vld[LAT-1];
  assign last_tag = tags[LAT-1];

endmodule

// File: rtl/simd_result_wb.sv
// Writeback buffer behind the SIMD unit: tag pipe, DEPTH-entry FIFO, valid/ready output.
// Optional build macro SIMD_WB_BYPASS_EN lets a result skip an empty FIFO combinationally.
module simd_result_wb
  import simd_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 9,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [TAGW-1:0] tag,
  input  logic            flush,
  input  logic [67:0]     res_in,
  output logic            stall,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [TAGW-1:0] wb_tag,
  output logic [67:0]     wb_data,
  output logic            ovfl_err,
  output logic            fmt_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            last_vld;
  logic [TAGW-1:0] last_tag;
  logic [LAT-1:0]  vld_nxt;

  simd_tag_pipe #(.LAT(LAT), .TAGW(TAGW)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .tag      (tag),
    .last_vld (last_vld),
    .last_tag (last_tag),
    .vld_nxt  (vld_nxt)
  );

  simd_wb_entry_t  mem [DEPTH];
  simd_wb_entry_t  head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [15:0]     sum_nxt;
  logic            empty, full, bypass, push, pop, wr_en, cap;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

`ifdef SIMD_WB_BYPASS_EN
  assign bypass = empty & last_vld & wb_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign cap   = last_vld & ~flush;
  assign push  = last_vld & ~bypass;
  assign pop   = ~empty & wb_ready;
  // At full, a same-edge pop frees the slot this push lands in.
  assign wr_en = push & (~full | pop);

  always_comb begin
    count_nxt = count;
    if (flush)              count_nxt = '0;
    else if (wr_en & ~pop)  count_nxt = count + CW'(1);
    else if (pop & ~wr_en)  count_nxt = count - CW'(1);
  end

  assign sum_nxt = 16'(count_nxt) + pcount(32'(vld_nxt));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stall    <= 1'b0;
      ovfl_err <= 1'b0;
      fmt_err  <= 1'b0;
    end else begin
      count <= count_nxt;
      stall <= (sum_nxt >= 16'(DEPTH - 1));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)               wr_ptr   <= wr_ptr + PW'(1);
        if (pop)                 rd_ptr   <= rd_ptr + PW'(1);
        if (push & full & ~pop)  ovfl_err <= 1'b1;
        if (cap & fmt_bad(res_in)) fmt_err <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (wr_en & ~flush) mem[wr_ptr] <= '{tag: last_tag, data: res_in};
  end

  // Outputs are forced to zero when empty so reset and flush present a clean bus.
  always_comb begin
    wb_valid = ~empty;
    wb_tag   = empty ? '0 : head.tag;
    wb_data  = empty ? '0 : head.data;
    if (bypass) begin
      wb_valid = 1'b1;
      wb_tag   = last_tag;
      wb_data  = res_in;
    end
  end

endmodule

// File: tb/tb_simd_result_wb.sv
// Directed bench for simd_result_wb (default build, no bypass).
// Inputs change just after posedge; the design updates on negedge.
module tb_simd_result_wb;
  import simd_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, flush, wb_ready;
  logic [8:0]  tag;
  logic [67:0] res_in, sp0, sp1;
  logic        stall, wb_valid, ovfl_err, fmt_err;
  logic [8:0]  wb_tag;
  logic [67:0] wb_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  simd_result_wb dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tag      (tag),
    .flush    (flush),
    .res_in   (res_in),
    .stall    (stall),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_tag   (wb_tag),
    .wb_data  (wb_data),
    .ovfl_err (ovfl_err),
    .fmt_err  (fmt_err)
  );

  function automatic logic [67:0] dat(input logic [8:0] t);
    dat = {4'h0, 28'hABCDEF0, 4'h2, 23'h0, t};
  endfunction

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: drive issue/ready, and model the SIMD unit returning data two clocks later.
  task automatic drive(input logic e, input logic [8:0] t, input logic [67:0] d, input logic r);
    en       = e;
    tag      = t;
    wb_ready = r;
    res_in   = sp1;
    sp1      = sp0;
    sp0      = e ? d : '0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 9'h0, 68'h0, r);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; wb_ready = 1'b0; tag = '0;
    res_in = '0; sp0 = '0; sp1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [8:0] t, input logic [67:0] d);
    chk({name, "_valid"}, 80'(wb_valid), 80'(1));
    chk({name, "_tag"}, 80'(wb_tag), 80'(t));
    chk({name, "_data"}, 80'(wb_data), 80'(d));
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_valid"}, 80'(wb_valid), 80'(0));
    chk({name, "_stall"}, 80'(stall), 80'(0));
    chk({name, "_ovfl"}, 80'(ovfl_err), 80'(0));
    chk({name, "_fmt"}, 80'(fmt_err), 80'(0));
    chk({name, "_tag"}, 80'(wb_tag), 80'(0));
    chk({name, "_data"}, 80'(wb_data), 80'(0));
  endtask

  initial begin
    logic [67:0] d0, d5;
    d0 = 68'h2_0000_0001_0000_0002;
    d5 = 68'h0_CAFE_0001_1234_5678;

    do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero_outs("reset");
    rst = 1'b0;

    // Single op: visible three clocks after issue, exactly one pulse.
    drive(1'b1, 9'h015, d0, 1'b1);
    chk("single_c1_valid", 80'(wb_valid), 80'(0));
    idle(1'b1);
    chk("single_c2_valid", 80'(wb_valid), 80'(0));
    idle(1'b1);
    chk_head("single_c3", 9'h015, d0);
    idle(1'b1);
    chk("single_c4_valid", 80'(wb_valid), 80'(0));
    chk("single_fmt_guard65", 80'(fmt_err), 80'(1));

    do_reset();
    chk("reset2_fmt", 80'(fmt_err), 80'(0));

    // Backpressure: stall rises once count+inflight reaches 3.
    drive(1'b1, 9'h001, dat(9'h001), 1'b0);
    chk("bp_stall_c0", 80'(stall), 80'(0));
    drive(1'b1, 9'h002, dat(9'h002), 1'b0);
    chk("bp_stall_c1", 80'(stall), 80'(0));
    drive(1'b1, 9'h003, dat(9'h003), 1'b0);
    chk("bp_stall_c2", 80'(stall), 80'(1));
    idle(1'b0);
    idle(1'b0);
    chk("bp_stall_held", 80'(stall), 80'(1));
    chk_head("bp_head", 9'h001, dat(9'h001));
    idle(1'b0);
    chk_head("bp_stable", 9'h001, dat(9'h001));
    for (int i = 1; i <= 3; i++) begin
      chk_head("bp_drain", 9'(i), dat(9'(i)));
      idle(1'b1);
    end
    chk("bp_empty", 80'(wb_valid), 80'(0));
    chk("bp_stall_low", 80'(stall), 80'(0));
    chk("bp_ovfl", 80'(ovfl_err), 80'(0));
    chk("bp_fmt", 80'(fmt_err), 80'(0));

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 5; i++) drive(1'b1, 9'(9'h021 + i), dat(9'(9'h021 + i)), 1'b0);
    idle(1'b0);
    chk_head("full_head", 9'h021, dat(9'h021));
    idle(1'b1);
    chk("full_pp_ovfl", 80'(ovfl_err), 80'(0));
    for (int i = 0; i < 4; i++) begin
      chk_head("full_pp_drain", 9'(9'h022 + i), dat(9'(9'h022 + i)));
      idle(1'b1);
    end
    chk("full_pp_empty", 80'(wb_valid), 80'(0));

    // Forced overflow: fifth result dropped while full and not ready.
    for (int i = 0; i < 4; i++) drive(1'b1, 9'(9'h031 + i), dat(9'(9'h031 + i)), 1'b0);
    drive(1'b1, 9'h03F, dat(9'h03F), 1'b0);
    idle(1'b0);
    chk("ovfl_before", 80'(ovfl_err), 80'(0));
    idle(1'b0);
    chk("ovfl_set", 80'(ovfl_err), 80'(1));
    idle(1'b0);
    chk("ovfl_sticky", 80'(ovfl_err), 80'(1));
    for (int i = 0; i < 4; i++) begin
      chk_head("ovfl_drain", 9'(9'h031 + i), dat(9'(9'h031 + i)));
      idle(1'b1);
    end
    chk("ovfl_no_dropped", 80'(wb_valid), 80'(0));
    chk("ovfl_still", 80'(ovfl_err), 80'(1));
    flush = 1'b1;
    idle(1'b0);
    flush = 1'b0;
    chk("ovfl_survives_flush", 80'(ovfl_err), 80'(1));

    do_reset();
    chk("reset3_ovfl", 80'(ovfl_err), 80'(0));

    // Flush with two ops in the pipe and one buffered.
    drive(1'b1, 9'h041, dat(9'h041), 1'b0);
    drive(1'b1, 9'h042, dat(9'h042), 1'b0);
    drive(1'b1, 9'h043, dat(9'h043), 1'b0);
    chk_head("flush_pre", 9'h041, dat(9'h041));
    flush = 1'b1;
    idle(1'b0);
    flush = 1'b0;
    chk("flush_valid", 80'(wb_valid), 80'(0));
    chk("flush_stall", 80'(stall), 80'(0));
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("flush_nothing", 80'(wb_valid), 80'(0));
    end
    drive(1'b1, 9'h1FF, dat(9'h1FF), 1'b1);
    idle(1'b1);
    chk("post_flush_c2", 80'(wb_valid), 80'(0));
    idle(1'b1);
    chk_head("post_flush", 9'h1FF, dat(9'h1FF));
    idle(1'b1);
    chk("post_flush_done", 80'(wb_valid), 80'(0));

    // Format error, delivered unmodified, then async reset mid-drain.
    chk("fmt_clean", 80'(fmt_err), 80'(0));
    drive(1'b1, 9'h051, d5, 1'b0);
    drive(1'b1, 9'h052, dat(9'h052), 1'b0);
    idle(1'b0);
    chk("fmt_set", 80'(fmt_err), 80'(1));
    idle(1'b0);
    chk_head("fmt_head", 9'h051, d5);
    idle(1'b1);
    chk_head("fmt_next", 9'h052, dat(9'h052));
    #2 rst = 1'b1;
    #1;
    chk_zero_outs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1);
    chk("after_rst_valid", 80'(wb_valid), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
